// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM-subset control sequencer.
// Contents: FSM state encoding, condition codes, instruction class codes,
// data-processing opcodes, flag bit indices and opcode helper functions.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LDST   = 3'b010;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Arithmetic opcodes produce a meaningful V from the adder.
    function automatic logic is_arith(input logic [3:0] op);
        return (op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN});
    endfunction

    // TST/TEQ/CMP/CMN only set flags and never write a register.
    function automatic logic is_compare(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator.
// Ports: cond   - instruction condition field [31:28]
//        flags  - current {N,Z,C,V}
//        cond_met - 1 when the instruction should execute
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_met
);

    logic n, z, c, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_met = 1'b0;
        case (cond)
            COND_EQ: cond_met = z;
            COND_NE: cond_met = ~z;
            COND_CS: cond_met = c;
            COND_CC: cond_met = ~c;
            COND_MI: cond_met = n;
            COND_PL: cond_met = ~n;
            COND_VS: cond_met = v;
            COND_VC: cond_met = ~v;
            COND_HI: cond_met = c & ~z;
            COND_LS: cond_met = ~c | z;
            COND_GE: cond_met = (n == v);
            COND_LT: cond_met = (n != v);
            COND_GT: cond_met = ~z & (n == v);
            COND_LE: cond_met = z | (n != v);
            COND_AL: cond_met = 1'b1;
            default: cond_met = 1'b0;   // NV
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle control sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Owns PC, NZCV flags, condition evaluation and register write control.
// Ports: clk/reset (async, active-high); inst_req/inst_ack/inst_i fetch
// handshake, inst_o latched instruction; alu_flags and wb_data from the
// datapath; mem_req/mem_we/mem_ack data-memory handshake; reg_we/wb_addr/
// link_addr register write control; pc, flags, cond_met, state, bus_err.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int RESET_PC    = 0,
    parameter int PC_LIMIT    = 64,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              inst_req,
    input  logic              inst_ack,
    input  logic [31:0]       inst_i,
    output logic [31:0]       inst_o,
    input  logic [3:0]        alu_flags,
    input  logic [ADDR_W-1:0] wb_data,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              reg_we,
    output logic [3:0]        wb_addr,
    output logic [ADDR_W-1:0] link_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        flags,
    output logic              cond_met,
    output logic [2:0]        state,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_LIMIT_W = ADDR_W'(PC_LIMIT);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [3:0]        flags_reg, flags_next;
    logic [31:0]       inst_reg, inst_next;
    logic              cond_met_reg, cond_met_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic              mem_fail_reg, mem_fail_next;
    logic              bus_err_reg, bus_err_next;

    logic              cond_now;
    logic [2:0]        cls;
    logic [3:0]        opcode;
    logic              is_dp, is_ldst, is_branch, is_link;
    logic              wb_write, flag_wr;
    logic [3:0]        flag_load, flags_upd;
    logic [ADDR_W-1:0] br_target, seq_pc;
    logic              unused_wb_lsb;

    cond_check u_cond (
        .cond     (inst_reg[31:28]),
        .flags    (flags_reg),
        .cond_met (cond_now)
    );

    assign cls       = inst_reg[27:25];
    assign opcode    = inst_reg[24:21];
    assign is_dp     = (cls == CLS_DP_REG) || (cls == CLS_DP_IMM);
    assign is_ldst   = (cls == CLS_LDST);
    assign is_branch = (cls == CLS_BRANCH);
    assign is_link   = is_branch && inst_reg[24];

    // Decisions after DECODE use the latched condition so that a flag update
    // in EXEC cannot change whether this same instruction writes back.
    assign flag_wr  = cond_met_reg && inst_reg[20] && is_dp;
    assign wb_write = cond_met_reg &&
                      ((is_dp && !is_compare(opcode)) ||
                       (is_ldst && inst_reg[20] && !mem_fail_reg) ||
                       is_link);

    // Logical ops leave V untouched; N, Z and C always load.
    assign flag_load = {3'b111, is_arith(opcode)};
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_flag
            assign flags_upd[gi] = flag_load[gi] ? alu_flags[gi] : flags_reg[gi];
        end
    endgenerate

    // Branch target deliberately skips the PC_LIMIT wrap.
    assign br_target = pc_reg + ADDR_W'(8)
                     + ADDR_W'($signed({inst_reg[23:0], 2'b00}));
    assign seq_pc    = (pc_reg >= PC_LIMIT_W) ? '0 : pc_reg + ADDR_W'(4);

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        flags_next    = flags_reg;
        inst_next     = inst_reg;
        cond_met_next = cond_met_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_fail_next = mem_fail_reg;
        bus_err_next  = bus_err_reg;
        inst_req      = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        reg_we        = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                inst_req = 1'b1;
                if (inst_ack) begin
                    inst_next  = inst_i;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cond_met_next = cond_now;
                wait_cnt_next = '0;
                mem_fail_next = 1'b0;
                state_next    = ST_EXEC;
            end
            ST_EXEC: begin
                if (flag_wr) begin
                    flags_next = flags_upd;
                end
                state_next = (is_ldst && cond_met_reg) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = ~inst_reg[20];
                // ack is checked first so a last-cycle ack still completes.
                if (mem_ack) begin
                    state_next = ST_WB;
                end else if (wait_cnt_reg == CNT_LAST) begin
                    mem_fail_next = 1'b1;
                    bus_err_next  = 1'b1;
                    state_next    = ST_WB;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            ST_WB: begin
                reg_we = wb_write;
                if (is_branch && cond_met_reg) begin
                    pc_next = br_target;
                end else if (wb_write && (wb_addr == 4'd15)) begin
                    pc_next = {wb_data[ADDR_W-1:2], 2'b00};
                end else begin
                    pc_next = seq_pc;
                end
                state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_FETCH;
            pc_reg       <= PC_RST;
            flags_reg    <= 4'b0000;
            inst_reg     <= '0;
            cond_met_reg <= 1'b0;
            wait_cnt_reg <= '0;
            mem_fail_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            flags_reg    <= flags_next;
            inst_reg     <= inst_next;
            cond_met_reg <= cond_met_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_fail_reg <= mem_fail_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    assign unused_wb_lsb = ^wb_data[1:0];

    assign inst_o    = inst_reg;
    assign pc        = pc_reg;
    assign flags     = flags_reg;
    assign state     = state_reg;
    assign bus_err   = bus_err_reg;
    assign wb_addr   = is_link ? 4'd14 : inst_reg[15:12];
    assign link_addr = pc_reg + ADDR_W'(4);
    // During DECODE the live evaluation is shown; afterwards the latched one.
    assign cond_met  = (state_reg == ST_DECODE) ? cond_now : cond_met_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic        inst_ack;
    logic [31:0] inst_i;
    logic [31:0] inst_o;
    logic [3:0]  alu_flags;
    logic [31:0] wb_data;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        reg_we;
    logic [3:0]  wb_addr;
    logic [31:0] link_addr;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic        cond_met;
    logic [2:0]  st;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_sequencer #(
        .ADDR_W(32), .RESET_PC(0), .PC_LIMIT(64), .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_ack(inst_ack), .inst_i(inst_i), .inst_o(inst_o),
        .alu_flags(alu_flags), .wb_data(wb_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .reg_we(reg_we), .wb_addr(wb_addr), .link_addr(link_addr),
        .pc(pc), .flags(flags), .cond_met(cond_met), .state(st), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc0;
        logic [31:0] inst;
        logic [3:0]  alu;
        logic [31:0] wbd;
        int          fwait;   // cycles inst_ack held low
        int          mwait;   // MEM cycles before mem_ack (255 = never)
        int          cyc;     // FETCH..WB cycles
        logic        we;
        logic [3:0]  waddr;
        logic        cm;
        logic [31:0] pc_exp;
        logic [3:0]  fl;
        int          mreq;
        logic        mwe;
        logic        berr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc = 0, mreq = 0, wecnt = 0, w = 0, ireq = 0;
        logic mwe_s = 1'b0, cm_s = 1'b0;
        logic [3:0]  wa_s = 4'h0;
        logic [31:0] link_s = 32'h0;
        bit done = 0;
        check({nm, " start_pc"}, pc, v.pc0);
        inst_i    = v.inst;
        alu_flags = v.alu;
        wb_data   = v.wbd;
        mem_ack   = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (st == 3'd0 && cyc > v.fwait) begin
                done = 1;
                break;
            end
            if (st == 3'd0) begin
                inst_ack = (cyc >= v.fwait);
                ireq += int'(inst_req);
            end
            if (st == 3'd3) begin
                if (mreq == 0) mwe_s = mem_we;
                mreq += int'(mem_req);
                mem_ack = (w == v.mwait);
                w++;
            end else begin
                mem_ack = 1'b0;
            end
            if (reg_we) wecnt++;
            if (st == 3'd4) begin
                wa_s   = wb_addr;
                cm_s   = cond_met;
                link_s = link_addr;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        mem_ack = 1'b0;
        check({nm, " completed"}, 32'(done), 32'd1);
        check({nm, " cycles"}, 32'(cyc), 32'(v.cyc));
        check({nm, " inst_req_cycles"}, 32'(ireq), 32'(v.fwait + 1));
        check({nm, " reg_we_pulses"}, 32'(wecnt), 32'(v.we));
        check({nm, " wb_addr"}, 32'(wa_s), 32'(v.waddr));
        check({nm, " cond_met"}, 32'(cm_s), 32'(v.cm));
        check({nm, " link_addr"}, link_s, v.pc0 + 32'd4);
        check({nm, " pc"}, pc, v.pc_exp);
        check({nm, " flags"}, 32'(flags), 32'(v.fl));
        check({nm, " mem_req_cycles"}, 32'(mreq), 32'(v.mreq));
        if (v.mreq > 0) check({nm, " mem_we"}, 32'(mwe_s), 32'(v.mwe));
        check({nm, " bus_err"}, 32'(bus_err), 32'(v.berr));
        $display("%s inst=%08h pc %08h->%08h flags=%b cycles=%0d reg_we=%0d wb_addr=%0d",
                 nm, v.inst, v.pc0, pc, flags, cyc, wecnt, wa_s);
    endtask

    initial begin
        vec_t h;
        int k;
        //            pc0     inst          alu     wbd    fw mw  cyc we waddr cm pc_exp   fl     mreq mwe berr
        vecs[0]  = '{32'h00, 32'hE0901000, 4'b0110, 32'h0, 0, 0,   4, 1, 4'd1,  1, 32'h04, 4'b0110, 0, 0, 0}; // ADDS r1
        vecs[1]  = '{32'h04, 32'hE1500000, 4'b0101, 32'h0, 0, 0,   4, 0, 4'd0,  1, 32'h08, 4'b0101, 0, 0, 0}; // CMP
        vecs[2]  = '{32'h08, 32'hE0402000, 4'b1111, 32'h0, 2, 0,   6, 1, 4'd2,  1, 32'h0C, 4'b0101, 0, 0, 0}; // SUB, fetch stall
        vecs[3]  = '{32'h0C, 32'h10903000, 4'b1000, 32'h0, 0, 0,   4, 0, 4'd3,  0, 32'h10, 4'b0101, 0, 0, 0}; // ADDNES false
        vecs[4]  = '{32'h10, 32'h0AFFFFFE, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd15, 1, 32'h10, 4'b0101, 0, 0, 0}; // BEQ taken
        vecs[5]  = '{32'h10, 32'hE1B0F000, 4'b0000, 32'h13,0, 0,   4, 1, 4'd15, 1, 32'h10, 4'b0001, 0, 0, 0}; // MOVS pc
        vecs[6]  = '{32'h10, 32'h0AFFFFFE, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd15, 0, 32'h14, 4'b0001, 0, 0, 0}; // BEQ not taken
        vecs[7]  = '{32'h14, 32'hE1A0F000, 4'b1111, 32'h08,0, 0,   4, 1, 4'd15, 1, 32'h08, 4'b0001, 0, 0, 0}; // MOV pc
        vecs[8]  = '{32'h08, 32'hEB000002, 4'b0000, 32'h0, 0, 0,   4, 1, 4'd14, 1, 32'h18, 4'b0001, 0, 0, 0}; // BL
        vecs[9]  = '{32'h18, 32'hE4105000, 4'b1111, 32'h0, 0, 3,   8, 1, 4'd5,  1, 32'h1C, 4'b0001, 4, 0, 0}; // LDR 3 waits
        vecs[10] = '{32'h1C, 32'hE4108000, 4'b1111, 32'h0, 0, 14, 19, 1, 4'd8,  1, 32'h20, 4'b0001, 15,0, 0}; // LDR ack on last cycle
        vecs[11] = '{32'h20, 32'hE4006000, 4'b0000, 32'h0, 0, 255,19, 0, 4'd6,  1, 32'h24, 4'b0001, 15,1, 1}; // STR timeout
        vecs[12] = '{32'h24, 32'h04107000, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd7,  0, 32'h28, 4'b0001, 0, 0, 1}; // LDREQ false
        vecs[13] = '{32'h28, 32'hDA000000, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd0,  1, 32'h30, 4'b0001, 0, 0, 1}; // BLE taken
        vecs[14] = '{32'h30, 32'hE1500000, 4'b0010, 32'h0, 0, 0,   4, 0, 4'd0,  1, 32'h34, 4'b0010, 0, 0, 1}; // CMP
        vecs[15] = '{32'h34, 32'h9A000000, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd0,  0, 32'h38, 4'b0010, 0, 0, 1}; // BLS false
        vecs[16] = '{32'h38, 32'h8A000000, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd0,  1, 32'h40, 4'b0010, 0, 0, 1}; // BHI taken
        vecs[17] = '{32'h40, 32'hFA000000, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd0,  0, 32'h00, 4'b0010, 0, 0, 1}; // BNV, wrap
        vecs[18] = '{32'h00, 32'hE1100000, 4'b1101, 32'h0, 0, 0,   4, 0, 4'd0,  1, 32'h04, 4'b1100, 0, 0, 1}; // TST
        vecs[19] = '{32'h04, 32'hCA000000, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd0,  0, 32'h08, 4'b1100, 0, 0, 1}; // BGT false
        vecs[20] = '{32'h08, 32'h4A000000, 4'b0000, 32'h0, 0, 0,   4, 0, 4'd0,  1, 32'h10, 4'b1100, 0, 0, 1}; // BMI taken

        reset = 1'b1; inst_ack = 1'b0; inst_i = 32'h0; alu_flags = 4'h0;
        wb_data = 32'h0; mem_ack = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst state", 32'(st), 32'd0);
        check("rst pc", pc, 32'h0);
        check("rst flags", 32'(flags), 32'h0);
        check("rst inst_o", inst_o, 32'h0);
        check("rst bus_err", 32'(bus_err), 32'h0);
        check("rst reg_we", 32'(reg_we), 32'h0);
        check("rst mem_req", 32'(mem_req), 32'h0);
        check("rst inst_req", 32'(inst_req), 32'h1);
        @(posedge clk);
        #1;

        // Reset in the middle of a load: abort without side effects.
        h = '{32'h00, 32'hE0901000, 4'b1000, 32'h0, 0, 0, 4, 1, 4'd1, 1, 32'h04, 4'b1000, 0, 0, 0};
        run_vec(h, "pre-abort ADDS");
        inst_i = 32'hE4105000; inst_ack = 1'b1; mem_ack = 1'b0;
        k = 0;
        while (st != 3'd3 && k < 10) begin
            @(posedge clk); #1; k++;
        end
        inst_ack = 1'b0;
        check("abort reached MEM", 32'(st), 32'd3);
        @(posedge clk); #1;
        check("abort mem_req before reset", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort mem_req", 32'(mem_req), 32'd0);
        check("abort state", 32'(st), 32'd0);
        check("abort pc", pc, 32'h0);
        check("abort flags", 32'(flags), 32'h0);
        check("abort reg_we", 32'(reg_we), 32'd0);
        check("abort bus_err", 32'(bus_err), 32'd0);
        $display("reset mid-MEM: state=%0d pc=%08h mem_req=%0d", st, pc, mem_req);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end
        inst_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
